dmem_responder: RTL and testbench

//  Target side of the CPU data-memory interface: services load/store requests issued by the datapath.

---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_if.sv | 32 +++
 rtl/dmem_array.sv | 27 ++
 rtl/dmem_responder.sv | 137 +++++++++++++
 tb/tb_dmem_responder.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding
// and the wait-state counter width.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the datapath (master) and a data memory
// responder (slave).
//
// Handshake semantics: on both channels a transfer happens on a rising
// clk edge where valid and ready are both 1. The master holds req_* stable
// while req_valid=1 and req_ready=0; the slave holds rsp_* stable while
// rsp_valid=1 and rsp_ready=0. ready carries no meaning when valid is 0.
interface dmem_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_array.sv
// Word storage: synchronous write, asynchronous read. Contents are not
// affected by reset.
module dmem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 128,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port: one word per cycle when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Target side of the CPU data-memory interface. Accepts one request at a
// time, inserts WAIT_CYCLES wait states, commits the access on the edge
// entering RESP and holds the response until the initiator takes it.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 2
) (
    input  logic   clk,
    input  logic   reset,
    dmem_if.slave  bus,
    output state_t dbg_state
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    // Access being committed this cycle (latched request, or the live
    // request when there are no wait states).
    logic              commit;
    logic              c_write;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_err;
    logic              arr_we;
    logic [DATA_W-1:0] arr_rdata;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (c_addr[IDX_W-1:0]),
        .wdata (c_wdata),
        .raddr (c_addr[IDX_W-1:0]),
        .rdata (arr_rdata)
    );

    // Next-state, wait counter, request latch and commit of the access.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;
        c_write = write_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                        c_write = bus.req_write;
                        c_addr  = bus.req_addr;
                        c_wdata = bus.req_wdata;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Out-of-range check uses every address bit, so no aliasing.
        c_err = (c_addr >= ADDR_W'(DEPTH));
        if (commit) begin
            err_d   = c_err;
            rdata_d = (!c_write && !c_err) ? arr_rdata : '0;
        end
        // A reset on the commit edge drops the store.
        arr_we = commit && c_write && !c_err && !reset;
    end

    // State and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 uses two wait states, instance 1
// none. A transaction-level model predicts every output each cycle.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 128;

    logic clk;
    logic rst;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bench-side drive and observe arrays ----------------
    logic        t_valid     [2];
    logic        t_write     [2];
    logic [15:0] t_addr      [2];
    logic [15:0] t_wdata     [2];
    logic        t_rsp_ready [2];

    logic        o_req_ready [2];
    logic        o_rsp_valid [2];
    logic [15:0] o_rsp_rdata [2];
    logic        o_rsp_err   [2];
    state_t      dbg         [2];

    dmem_if #(.DATA_W(16), .ADDR_W(16)) bus0 ();
    dmem_if #(.DATA_W(16), .ADDR_W(16)) bus1 ();

    assign bus0.req_valid = t_valid[0];
    assign bus0.req_write = t_write[0];
    assign bus0.req_addr  = t_addr[0];
    assign bus0.req_wdata = t_wdata[0];
    assign bus0.rsp_ready = t_rsp_ready[0];
    assign bus1.req_valid = t_valid[1];
    assign bus1.req_write = t_write[1];
    assign bus1.req_addr  = t_addr[1];
    assign bus1.req_wdata = t_wdata[1];
    assign bus1.rsp_ready = t_rsp_ready[1];

    assign o_req_ready[0] = bus0.req_ready;
    assign o_rsp_valid[0] = bus0.rsp_valid;
    assign o_rsp_rdata[0] = bus0.rsp_rdata;
    assign o_rsp_err[0]   = bus0.rsp_err;
    assign o_req_ready[1] = bus1.req_ready;
    assign o_rsp_valid[1] = bus1.rsp_valid;
    assign o_rsp_rdata[1] = bus1.rsp_rdata;
    assign o_rsp_err[1]   = bus1.rsp_err;

    dmem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .WAIT_CYCLES(2)) u_dut0 (
        .clk       (clk),
        .reset     (rst),
        .bus       (bus0.slave),
        .dbg_state (dbg[0])
    );

    dmem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut1 (
        .clk       (clk),
        .reset     (rst),
        .bus       (bus1.slave),
        .dbg_state (dbg[1])
    );

    // ---------------- scoreboard counters ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic fail_timeout(input string nm);
        n_chk++;
        $display("FAIL %s: timed out (t=%0t)", nm, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Each instance is either free, or holds one transaction that commits
    // at edge m_start and is visible from then until it is taken.
    int          cyc = 0;
    bit          m_armed = 0;
    bit          m_busy  [2] = '{0, 0};
    bit          m_zero  [2] = '{1, 1};
    int          m_start [2];
    bit          m_w     [2];
    logic [15:0] m_a     [2];
    logic [15:0] m_d     [2];
    logic [15:0] m_rd    [2];
    bit          m_err   [2];
    logic [15:0] m_mem   [2][DEPTH];

    initial begin
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < DEPTH; j++) m_mem[i][j] = 16'h0;
    end

    function automatic int wait_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic void model_commit(input int i);
        m_err[i] = (m_a[i] >= 16'(DEPTH));
        if (m_err[i]) m_rd[i] = 16'h0;
        else if (m_w[i]) begin
            m_mem[i][m_a[i]] = m_d[i];
            m_rd[i] = 16'h0;
        end else m_rd[i] = m_mem[i][m_a[i]];
        m_zero[i] = 0;
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_busy[i] = 0;
                m_zero[i] = 1;
                m_armed   = 1;
            end else if (!m_busy[i]) begin
                if (t_valid[i]) begin
                    m_busy[i]  = 1;
                    m_w[i]     = t_write[i];
                    m_a[i]     = t_addr[i];
                    m_d[i]     = t_wdata[i];
                    m_start[i] = cyc + wait_of(i);
                    if (wait_of(i) == 0) model_commit(i);
                end
            end else if (cyc == m_start[i]) begin
                model_commit(i);
            end else if (cyc > m_start[i] && t_rsp_ready[i]) begin
                m_busy[i] = 0;
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_armed) begin
            for (int i = 0; i < 2; i++) begin
                bit ev;
                logic [1:0] es;
                ev = m_busy[i] && (cyc >= m_start[i]);
                es = !m_busy[i] ? 2'd0 : (ev ? 2'd2 : 2'd1);
                chk($sformatf("req_ready[%0d]", i), 32'(o_req_ready[i]), 32'(!m_busy[i]));
                chk($sformatf("rsp_valid[%0d]", i), 32'(o_rsp_valid[i]), 32'(ev));
                chk($sformatf("state[%0d]", i), 32'(dbg[i]), 32'(es));
                if (ev) begin
                    chk($sformatf("rsp_rdata[%0d]", i), 32'(o_rsp_rdata[i]), 32'(m_rd[i]));
                    chk($sformatf("rsp_err[%0d]", i), 32'(o_rsp_err[i]), 32'(m_err[i]));
                end else if (m_zero[i]) begin
                    chk($sformatf("rst_rdata[%0d]", i), 32'(o_rsp_rdata[i]), 32'h0);
                    chk($sformatf("rst_err[%0d]", i), 32'(o_rsp_err[i]), 32'h0);
                end
            end
        end
    end

    // ---------------- driver ----------------
    // hold >= 0: refuse the response for that many visible cycles, then take
    // it; hold < 0: take it at a random point. Junk is driven on the request
    // lines while busy to show it is ignored.
    task automatic txn(input int i, input bit w, input logic [15:0] a, input logic [15:0] d,
                       input int hold, output logic [15:0] rd, output logic er,
                       output int lat, output int acc);
        int n;
        int seen;
        rd = 16'h0; er = 1'b0; lat = -1; acc = -1; seen = 0;
        @(negedge clk);
        t_valid[i] = 1'b1; t_write[i] = w; t_addr[i] = a; t_wdata[i] = d;
        t_rsp_ready[i] = 1'($urandom_range(0, 1));
        n = 0;
        while (o_req_ready[i] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            fail_timeout("accept");
            t_valid[i] = 1'b0;
            return;
        end
        @(posedge clk);
        #1 acc = cyc;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (o_rsp_valid[i] === 1'b1) begin
                if (lat < 0) lat = cyc - acc;
                seen++;
                if ((hold >= 0) ? (seen > hold) : ($urandom_range(0, 2) == 0)) begin
                    t_rsp_ready[i] = 1'b1;
                    t_valid[i]     = 1'b0;
                    rd = o_rsp_rdata[i];
                    er = o_rsp_err[i];
                    @(posedge clk);
                    break;
                end
                t_rsp_ready[i] = 1'b0;
            end else begin
                t_rsp_ready[i] = 1'($urandom_range(0, 1));
            end
            t_valid[i] = 1'($urandom_range(0, 1));
            t_write[i] = 1'($urandom_range(0, 1));
            t_addr[i]  = 16'($urandom_range(0, 65535));
            t_wdata[i] = 16'($urandom_range(0, 65535));
            if (n >= 60) begin
                fail_timeout("response");
                t_valid[i] = 1'b0;
                break;
            end
        end
    endtask

    function automatic logic [15:0] rand_addr();
        int s;
        s = $urandom_range(0, 9);
        if (s == 0) return 16'($urandom_range(DEPTH, 65535));
        if (s < 5)  return 16'($urandom_range(0, 7));
        return 16'($urandom_range(0, DEPTH - 1));
    endfunction

    // ---------------- stimulus ----------------
    logic [15:0] rd;
    logic        er;
    int          lat;
    int          acc;
    int          prev_acc;

    initial begin
        for (int i = 0; i < 2; i++) begin
            t_valid[i] = 1'b0; t_write[i] = 1'b0; t_addr[i] = 16'h0;
            t_wdata[i] = 16'h0; t_rsp_ready[i] = 1'b0;
        end
        rst = 1'b1;
        // reset together with a pending request: nothing may be accepted
        @(negedge clk);
        t_valid[0] = 1'b1; t_addr[0] = 16'd3;
        @(negedge clk);
        t_valid[0] = 1'b0;
        chk("reset req_ready", 32'(o_req_ready[0]), 32'h1);
        chk("reset rsp_valid", 32'(o_rsp_valid[0]), 32'h0);
        rst = 1'b0;

        // storage starts unknown in silicon; fill it with zeros
        for (int j = 0; j < DEPTH; j++) begin
            txn(0, 1'b1, 16'(j), 16'h0, 0, rd, er, lat, acc);
            txn(1, 1'b1, 16'(j), 16'h0, 0, rd, er, lat, acc);
        end

        // store then load addr 10; response visible WAIT_CYCLES edges after accept
        txn(0, 1'b1, 16'd10, 16'h00A5, 0, rd, er, lat, acc);
        chk("t1 store rdata", 32'(rd), 32'h0);
        chk("t1 store err", 32'(er), 32'h0);
        chk("t1 store latency", 32'(lat), 32'd2);
        txn(0, 1'b0, 16'd10, 16'h0, 0, rd, er, lat, acc);
        chk("t1 load rdata", 32'(rd), 32'h00A5);
        chk("t1 load err", 32'(er), 32'h0);
        chk("t1 load latency", 32'(lat), 32'd2);

        // out of range: no aliasing onto addr 72
        txn(0, 1'b0, 16'd200, 16'h0, 0, rd, er, lat, acc);
        chk("t2 load err", 32'(er), 32'h1);
        chk("t2 load rdata", 32'(rd), 32'h0);
        txn(0, 1'b1, 16'd200, 16'hFFFF, 0, rd, er, lat, acc);
        chk("t2 store err", 32'(er), 32'h1);
        txn(0, 1'b0, 16'd72, 16'h0, 0, rd, er, lat, acc);
        chk("t2 alias rdata", 32'(rd), 32'h0);

        // response held for 5 cycles while request lines toggle
        txn(0, 1'b0, 16'd10, 16'h0, 5, rd, er, lat, acc);
        chk("t3 held rdata", 32'(rd), 32'h00A5);

        // reset while in WAIT (first wait cycle): store dropped
        @(negedge clk);
        t_valid[0] = 1'b1; t_write[0] = 1'b1; t_addr[0] = 16'd5; t_wdata[0] = 16'h1234;
        t_rsp_ready[0] = 1'b0;
        @(negedge clk);
        t_valid[0] = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        txn(0, 1'b0, 16'd5, 16'h0, 0, rd, er, lat, acc);
        chk("t5 wait-reset rdata", 32'(rd), 32'h0);

        // reset on the edge that would commit: store dropped
        @(negedge clk);
        t_valid[0] = 1'b1; t_write[0] = 1'b1; t_addr[0] = 16'd6; t_wdata[0] = 16'h4321;
        t_rsp_ready[0] = 1'b0;
        @(negedge clk);
        t_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        txn(0, 1'b0, 16'd6, 16'h0, 0, rd, er, lat, acc);
        chk("t5 commit-reset rdata", 32'(rd), 32'h0);

        // reset while in RESP: store already done, response discarded
        @(negedge clk);
        t_valid[0] = 1'b1; t_write[0] = 1'b1; t_addr[0] = 16'd7; t_wdata[0] = 16'h7777;
        t_rsp_ready[0] = 1'b0;
        @(negedge clk);
        t_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        txn(0, 1'b0, 16'd7, 16'h0, 0, rd, er, lat, acc);
        chk("t5 resp-reset rdata", 32'(rd), 32'h7777);

        // top boundary address
        txn(0, 1'b1, 16'd127, 16'h8001, 0, rd, er, lat, acc);
        txn(0, 1'b0, 16'd127, 16'h0, 0, rd, er, lat, acc);
        chk("t6 top rdata", 32'(rd), 32'h8001);
        chk("t6 top err", 32'(er), 32'h0);
        txn(0, 1'b0, 16'd128, 16'h0, 0, rd, er, lat, acc);
        chk("t6 first bad err", 32'(er), 32'h1);

        // randomized traffic with random response back-pressure
        for (int k = 0; k < 200; k++)
            txn(0, 1'($urandom_range(0, 1)), rand_addr(), 16'($urandom_range(0, 65535)), -1,
                rd, er, lat, acc);

        // zero-wait instance: back-to-back stores every 2 cycles
        prev_acc = -1;
        for (int j = 0; j < 4; j++) begin
            txn(1, 1'b1, 16'(j), 16'(16'h0101 * (j + 1)), 0, rd, er, lat, acc);
            chk("t4 latency", 32'(lat), 32'd0);
            if (j > 0) chk("t4 spacing", 32'(acc - prev_acc), 32'd2);
            prev_acc = acc;
        end
        for (int j = 0; j < 4; j++) begin
            txn(1, 1'b0, 16'(j), 16'h0, 0, rd, er, lat, acc);
            chk("t4 load rdata", 32'(rd), 32'(16'h0101 * (j + 1)));
        end
        for (int k = 0; k < 150; k++)
            txn(1, 1'($urandom_range(0, 1)), rand_addr(), 16'($urandom_range(0, 65535)), -1,
                rd, er, lat, acc);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

endmodule
